// File: rtl/i2c_tmp101_responder.sv
// I2C slave emulating a TMP101 temperature sensor: answers {4'b1001, chip_select_i},
// returns a 16-bit temperature word MSB byte first and accepts a pointer-register write.
module i2c_tmp101_responder #(
  parameter int SdaHoldCycles = 8,
  parameter int SyncStages    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  chip_select_i,
  input  logic [15:0] temperature_i,
  input  logic        scl_i,
  inout  wire         sda_io,
  output logic [1:0]  pointer_o,
  output logic        busy_o,
  output logic        read_done_o
);

  localparam int HoldW = (SdaHoldCycles < 2) ? 1 : $clog2(SdaHoldCycles + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_IGNORE = 3'd2,
    ST_ACK    = 3'd3,
    ST_RX     = 3'd4,
    ST_TX     = 3'd5,
    ST_MACK   = 3'd6
  } state_e;

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_last_q, sda_last_q;
  logic                  scl_s, sda_s, sda_in_s;
  logic                  scl_rise_s, scl_fall_s, start_s, stop_s;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d, shift_in_s;
  logic [15:0] tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        ack_armed_q, ack_armed_d;
  logic        first_byte_q, first_byte_d;
  logic        mack_ok_q, mack_ok_d;
  logic [1:0]  pointer_q, pointer_d;
  logic        busy_q, busy_d;
  logic        read_done_q, read_done_d;

  logic             drive_q, tgt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             tgt_load_s, tgt_low_s, release_now_s;

  assign sda_in_s = sda_io;
  assign scl_s    = scl_sync_q[SyncStages-1];
  assign sda_s    = sda_sync_q[SyncStages-1];

  // START/STOP need SCL high on both samples so an SCL edge never masquerades as one
  assign scl_rise_s = scl_s & ~scl_last_q;
  assign scl_fall_s = ~scl_s & scl_last_q;
  assign start_s    = scl_s & scl_last_q & sda_last_q & ~sda_s;
  assign stop_s     = scl_s & scl_last_q & ~sda_last_q & sda_s;
  assign shift_in_s = {shift_q[6:0], sda_s};

  // Synchronizer chains plus last-value registers for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= {SyncStages{1'b1}};
      sda_sync_q <= {SyncStages{1'b1}};
      scl_last_q <= 1'b1;
      sda_last_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_in_s};
      scl_last_q <= scl_s;
      sda_last_q <= sda_s;
    end
  end

  // Protocol state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      tx_q         <= 16'h0000;
      rw_q         <= 1'b0;
      ack_armed_q  <= 1'b0;
      first_byte_q <= 1'b0;
      mack_ok_q    <= 1'b0;
      pointer_q    <= 2'b00;
      busy_q       <= 1'b0;
      read_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      rw_q         <= rw_d;
      ack_armed_q  <= ack_armed_d;
      first_byte_q <= first_byte_d;
      mack_ok_q    <= mack_ok_d;
      pointer_q    <= pointer_d;
      busy_q       <= busy_d;
      read_done_q  <= read_done_d;
    end
  end

  // Next-state logic; SDA changes are requested on SCL falls and applied after the hold delay
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tx_d          = tx_q;
    rw_d          = rw_q;
    ack_armed_d   = ack_armed_q;
    first_byte_d  = first_byte_q;
    mack_ok_d     = mack_ok_q;
    pointer_d     = pointer_q;
    busy_d        = busy_q;
    read_done_d   = 1'b0;
    tgt_load_s    = 1'b0;
    tgt_low_s     = 1'b0;
    release_now_s = 1'b0;

    if (stop_s) begin
      state_d       = ST_IDLE;
      busy_d        = 1'b0;
      release_now_s = 1'b1;
    end else if (start_s) begin
      state_d       = ST_ADDR;
      bit_cnt_d     = 3'd0;
      release_now_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_IGNORE: begin
          state_d = state_q;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_in_s[7:1] == {4'b1001, chip_select_i}) begin
                state_d      = ST_ACK;
                rw_d         = shift_in_s[0];
                busy_d       = 1'b1;
                ack_armed_d  = 1'b0;
                first_byte_d = 1'b1;
                if (shift_in_s[0]) begin
                  tx_d = (pointer_q == 2'b00) ? temperature_i : 16'h0000;
                end else begin
                  tx_d = tx_q;
                end
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ACK: begin
          if (scl_fall_s) begin
            tgt_load_s = 1'b1;
            if (!ack_armed_q) begin
              ack_armed_d = 1'b1;
              tgt_low_s   = 1'b1;
            end else begin
              ack_armed_d = 1'b0;
              bit_cnt_d   = 3'd0;
              if (rw_q) begin
                state_d   = ST_TX;
                tgt_low_s = ~tx_q[15];
              end else begin
                state_d   = ST_RX;
                tgt_low_s = 1'b0;
              end
            end
          end else begin
            state_d = ST_ACK;
          end
        end
        ST_RX: begin
          if (scl_rise_s) begin
            shift_d   = shift_in_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d      = ST_ACK;
              ack_armed_d  = 1'b0;
              first_byte_d = 1'b0;
              if (first_byte_q) begin
                pointer_d = shift_in_s[1:0];
              end else begin
                pointer_d = pointer_q;
              end
            end else begin
              state_d = ST_RX;
            end
          end else begin
            state_d = ST_RX;
          end
        end
        ST_TX: begin
          // bit_cnt wraps to zero on the eighth rise, marking the fall that ends the byte
          if (scl_rise_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else if (scl_fall_s) begin
            tx_d       = {tx_q[14:0], 1'b0};
            tgt_load_s = 1'b1;
            if (bit_cnt_q == 3'd0) begin
              state_d   = ST_MACK;
              mack_ok_d = 1'b0;
              tgt_low_s = 1'b0;
            end else begin
              tgt_low_s = ~tx_q[14];
            end
          end else begin
            state_d = ST_TX;
          end
        end
        ST_MACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              read_done_d = 1'b1;
              state_d     = ST_IDLE;
              busy_d      = 1'b0;
            end else begin
              mack_ok_d = 1'b1;
            end
          end else if (scl_fall_s && mack_ok_q) begin
            state_d    = ST_TX;
            bit_cnt_d  = 3'd0;
            tgt_load_s = 1'b1;
            tgt_low_s  = ~tx_q[15];
          end else begin
            state_d = ST_MACK;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Delayed SDA driver: a requested level takes effect SdaHoldCycles after the SCL fall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drive_q    <= 1'b0;
      tgt_q      <= 1'b0;
      hold_cnt_q <= '0;
    end else if (release_now_s) begin
      drive_q    <= 1'b0;
      tgt_q      <= 1'b0;
      hold_cnt_q <= '0;
    end else if (tgt_load_s) begin
      tgt_q      <= tgt_low_s;
      hold_cnt_q <= HoldW'(SdaHoldCycles);
    end else if (hold_cnt_q != '0) begin
      hold_cnt_q <= hold_cnt_q - HoldW'(1);
      if (hold_cnt_q == HoldW'(1)) begin
        drive_q <= tgt_q;
      end else begin
        drive_q <= drive_q;
      end
    end else begin
      drive_q <= drive_q;
    end
  end

  assign sda_io      = drive_q ? 1'b0 : 1'bz;
  assign pointer_o   = pointer_q;
  assign busy_o      = busy_q;
  assign read_done_o = read_done_q;

endmodule

// File: tb/tb_i2c_tmp101_responder.sv
// Bit-banged I2C master driving the TMP101 responder; observations are checked by a
// scoreboard monitor against expectations queued by the stimulus.
module tb_i2c_tmp101_responder;

  localparam int Q = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cs;
  logic [15:0] temp;
  logic        m_scl;
  logic        m_sda_low;
  logic [1:0]  pointer;
  logic        busy;
  logic        read_done;
  wire         sda;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_tmp101_responder dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .chip_select_i (cs),
    .temperature_i (temp),
    .scl_i         (m_scl),
    .sda_io        (sda),
    .pointer_o     (pointer),
    .busy_o        (busy),
    .read_done_o   (read_done)
  );

  string       exp_name_q[$];
  logic [15:0] exp_val_q[$];
  int          tests_run = 0;
  int          failed    = 0;
  logic        obs_valid = 1'b0;
  logic        drain_req = 1'b0;
  logic [15:0] obs_val   = 16'h0000;
  int          rd_cnt     = 0;
  int          drive_seen = 0;
  logic        mon_en     = 1'b0;

  // scoreboard monitor
  always @(posedge clk) begin
    if (obs_valid) begin
      tests_run++;
      if (exp_name_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_observation: got %h, nothing expected", obs_val);
      end else begin
        string       n;
        logic [15:0] v;
        n = exp_name_q.pop_front();
        v = exp_val_q.pop_front();
        if (obs_val !== v) begin
          failed++;
          $display("FAIL %s: got %h, expected %h", n, obs_val, v);
        end
      end
    end
    if (drain_req) begin
      tests_run++;
      if (exp_name_q.size() != 0) begin
        failed++;
        $display("FAIL scoreboard_drain: %0d expectations never observed", exp_name_q.size());
      end
    end
  end

  always @(posedge clk) if (read_done === 1'b1) rd_cnt++;
  always @(negedge clk) if (mon_en && !m_sda_low && sda === 1'b0) drive_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [15:0] e, input logic [15:0] a);
    exp_name_q.push_back(n);
    exp_val_q.push_back(e);
    obs_val   = a;
    obs_valid = 1'b1;
    @(negedge clk);
    obs_valid = 1'b0;
  endtask

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; q_wait();
    m_scl = 1'b1;     q_wait();
    m_sda_low = 1'b1; q_wait();
    m_scl = 1'b0;     q_wait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; q_wait();
    m_scl = 1'b1;     q_wait();
    m_sda_low = 1'b0; q_wait();
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; q_wait();
    m_scl = 1'b1;   q_wait(); q_wait();
    m_scl = 1'b0;   q_wait();
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; q_wait();
    m_scl = 1'b1;     q_wait();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    q_wait();
    m_scl = 1'b0;     q_wait();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, input int chg_at, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      if (i == chg_at) temp = 16'h2000;
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] b;
    int         r0;
    int         d0;

    rst_n = 1'b0; cs = 3'b000; temp = 16'h1980; m_scl = 1'b1; m_sda_low = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_pointer", 16'h0000, {14'd0, pointer});
    check("reset_busy", 16'h0000, {15'd0, busy});
    check("reset_read_done", 16'h0000, {15'd0, read_done});
    check("reset_sda", 16'h0001, {15'd0, sda === 1'b1});
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic two-byte read
    r0 = rd_cnt;
    i2c_start();
    write_byte(8'h91, ack);  check("t1_addr_ack", 16'h0000, {15'd0, ack});
    check("t1_busy_after_ack", 16'h0001, {15'd0, busy});
    read_byte(1'b0, -1, b);  check("t1_byte0", 16'h0019, {8'd0, b});
    check("t1_busy_mid", 16'h0001, {15'd0, busy});
    read_byte(1'b1, -1, b);  check("t1_byte1", 16'h0080, {8'd0, b});
    check("t1_read_done_cnt", 16'd1, 16'(rd_cnt - r0));
    i2c_stop();
    check("t1_busy_after_stop", 16'h0000, {15'd0, busy});

    // address mismatch
    r0 = rd_cnt; d0 = drive_seen; mon_en = 1'b1;
    i2c_start();
    write_byte(8'h93, ack);  check("t2_nack", 16'h0001, {15'd0, ack});
    check("t2_busy", 16'h0000, {15'd0, busy});
    read_byte(1'b1, -1, b);  check("t2_byte_ff", 16'h00ff, {8'd0, b});
    i2c_stop();
    mon_en = 1'b0;
    check("t2_no_drive", 16'd0, 16'(drive_seen - d0));
    check("t2_no_read_done", 16'd0, 16'(rd_cnt - r0));

    // pointer write, then reads
    i2c_start();
    write_byte(8'h90, ack);  check("t3_waddr_ack", 16'h0000, {15'd0, ack});
    write_byte(8'h01, ack);  check("t3_data_ack", 16'h0000, {15'd0, ack});
    check("t3_pointer1", 16'h0001, {14'd0, pointer});
    i2c_stop();
    i2c_start();
    write_byte(8'h91, ack);  check("t3_raddr_ack", 16'h0000, {15'd0, ack});
    read_byte(1'b0, -1, b);  check("t3_p1_byte0", 16'h0000, {8'd0, b});
    read_byte(1'b1, -1, b);  check("t3_p1_byte1", 16'h0000, {8'd0, b});
    i2c_stop();
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h00, ack);
    check("t3_pointer0", 16'h0000, {14'd0, pointer});
    i2c_stop();
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(1'b0, -1, b);  check("t3_p0_byte0", 16'h0019, {8'd0, b});
    read_byte(1'b1, -1, b);  check("t3_p0_byte1", 16'h0080, {8'd0, b});
    i2c_stop();

    // repeated START
    i2c_start();
    write_byte(8'h90, ack);  check("t4_waddr_ack", 16'h0000, {15'd0, ack});
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h91, ack);  check("t4_raddr_ack", 16'h0000, {15'd0, ack});
    read_byte(1'b1, -1, b);  check("t4_byte0", 16'h0019, {8'd0, b});
    i2c_stop();

    // reset while driving a zero data bit
    i2c_start();
    write_byte(8'h90, ack);
    write_byte(8'h02, ack);
    i2c_stop();
    check("t5_pointer2", 16'h0002, {14'd0, pointer});
    i2c_start();
    write_byte(8'h91, ack);  check("t5_addr_ack", 16'h0000, {15'd0, ack});
    q_wait();
    check("t5_tx_driving_low", 16'h0000, {15'd0, sda === 1'b1});
    rst_n = 1'b0;
    #1;
    s = (sda === 1'b1);
    check("t5_sda_released", 16'h0001, {15'd0, s});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_pointer_cleared", 16'h0000, {14'd0, pointer});
    check("t5_busy_cleared", 16'h0000, {15'd0, busy});
    i2c_stop();
    i2c_start();
    write_byte(8'h91, ack);  check("t5_post_ack", 16'h0000, {15'd0, ack});
    read_byte(1'b1, -1, b);  check("t5_post_byte0", 16'h0019, {8'd0, b});
    i2c_stop();

    // temperature change while a read is in flight
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(1'b0, 3, b);   check("t6_byte0", 16'h0019, {8'd0, b});
    read_byte(1'b1, -1, b);  check("t6_byte1", 16'h0080, {8'd0, b});
    i2c_stop();
    i2c_start();
    write_byte(8'h91, ack);
    read_byte(1'b1, -1, b);  check("t6_new_byte0", 16'h0020, {8'd0, b});
    i2c_stop();

    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/i2c_tmp101_responder.md
Name: i2c_tmp101_responder

Overview:
- I2C slave that emulates a TMP101 temperature sensor on the team's I2C bus.
- Responds to 7-bit address {4'b1001, ChipSelect}.
- Returns a 16-bit temperature word, MSB byte first, and accepts a pointer-register write.
- Serves as the bench and loopback target for the I2C temperature-read master, so the master can be exercised on a board without a physical TMP101.

Parameters:
- SdaHoldCycles, 8: system-clock cycles between a detected SCL falling edge and any change of the SDA drive, giving the data hold time.
- SyncStages, 2: flip-flop stages on SCL and SDA before edge detection; minimum 2.

Ports:
- Clock, input, 1: system clock, 75 MHz nominal.
- Reset, input, 1: asynchronous, active-low reset.
- ChipSelect, input, 3: low three address bits.
- Temperature, input, 16: {integer °C, fraction}; sampled into the shift register at the address ACK.
- SCL, input, 1: bus clock. The responder never stretches SCL.
- SDA, inout, 1: open drain. The block drives 1'b0 or 1'bz only, never 1'b1.
- Pointer, output, 2: current pointer register.
- Busy, output, 1: high from an address match until STOP or a return to IDLE.
- ReadDone, output, 1: one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset (Reset=0):
  - State=IDLE, SDA released (z), Pointer=2'b00, Busy=0, ReadDone=0.
  - Applies asynchronously, mid-transfer included. SDA is released within the same cycle Reset falls.
- Input conditioning:
  - SCL and SDA pass through SyncStages flip-flops.
  - Edges are detected against the last synchronized value, so edge latency is SyncStages+1 cycles.
- START: synchronized SDA falls while SCL=1. It is honoured in every state, which makes it a repeated START. It clears the bit counter and enters ADDR.
- STOP: synchronized SDA rises while SCL=1. It forces IDLE from any state, releases SDA and clears Busy.
- States:
  - IDLE: SDA released. Wait for START.
  - ADDR:
    - Shift SDA in MSB first on each SCL rise. 3-bit bit counter.
    - After bit 8: if shift[7:1]=={4'b1001,ChipSelect}, latch R/W=shift[0] and go to ADDR_ACK.
    - Otherwise go to IGNORE.
  - IGNORE: SDA released. Leave only on START or STOP.
  - ADDR_ACK:
    - SdaHoldCycles after the SCL fall that ends bit 8, drive SDA low.
    - Busy=1.
    - If R/W=1, load the TX shift register: Temperature when Pointer==0, else 16'h0000.
    - On the SCL fall ending the ACK clock: if R/W=1, go to TX with the first bit already presented after the hold delay. If R/W=0, release SDA and go to RX.
  - RX:
    - Receive 8 bits, then ACK exactly as in ADDR_ACK.
    - The first data byte after the address sets Pointer=byte[1:0]. Later bytes are ACKed and discarded.
    - Return to RX after each ACK.
  - TX:
    - Each bit is presented SdaHoldCycles after an SCL fall: drive low for 0, release for 1.
    - After 8 bits, release SDA and go to MACK.
  - MACK:
    - Sample SDA on the SCL rise.
    - 0 (ACK): shift in the next byte. After the low byte, further bytes are 8'h00. Return to TX.
    - 1 (NACK): pulse ReadDone and go to IDLE.
- SDA must remain stable whenever SCL=1, except through START or STOP.
- The responder must never detect its own SDA drive as a START or STOP. Changes occur only while SCL=0.
- Temperature is sampled once per read transaction. Changes during TX do not affect bytes in flight.
- A simultaneous START and SCL edge in the same cycle: START wins.
- Busy is not set on an address mismatch.

Test Plan:
- ChipSelect=3'b000, Temperature=16'h1980, master sends START, 8'h91, clocks 2 bytes with ACK then NACK, then STOP -> ACK low on the 9th clock; bytes read 8'h19 and 8'h80; ReadDone pulses once; Busy=1 from ACK to STOP.
- Master addresses 8'h93 with ChipSelect=3'b000 -> SDA never driven (stays z for the whole transaction); Busy=0; no ReadDone.
- Write 8'h90, 8'h01, STOP, then read 8'h91 for 2 bytes -> Pointer=2'b01 after the data ACK; read returns 8'h00, 8'h00. Then write 8'h90, 8'h00 and read again -> returns the Temperature bytes.
- Write 8'h90, 8'h00, repeated START, 8'h91, read 1 byte with NACK -> both address ACKs driven low; byte equals Temperature[15:8].
- Assert Reset low in the middle of a TX bit that is driving SDA low -> SDA goes z the same cycle; after release, the state is IDLE, Pointer=0, and the next valid START/read is answered normally.
- Temperature changes from 16'h1980 to 16'h2000 during the first TX byte -> bytes read are still 8'h19, 8'h80.
